// File: rtl/uart_temp_frame_rx.sv
// Purpose : receives the 3-byte core-temperature stream (8N1, LSB first) into per-core registers.
// Latency : byte_valid rises 2 + OVERSAMPLE/2 + 9*OVERSAMPLE edges after rx low first reaches sync flop 1.
// Backpr. : none; the serial line cannot be stalled, so every output is a 1-cycle pulse or a held register.
//
// Ports:
//   tranclk      clock, OVERSAMPLE x bit rate
//   rst_n        synchronous active-low reset
//   rx           asynchronous UART input, idle high
//   temp_core0-2 last valid byte received in frame slots 0..2
//   byte_valid   pulse: a temp_coreN register updated this cycle
//   frame_valid  pulse: slot 2 updated, frame complete
//   framing_err  pulse: stop bit sampled low, byte discarded
//   sync_lost    pulse: inter-byte idle timeout forced frame resync
//
// Optional feature: define UART_RX_TIMEOUT_EN to enable the inter-byte idle timeout.
// Without it, sync_lost is tied low and slot tracking advances only on valid bytes.

module uart_temp_frame_rx #(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       tranclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] temp_core0,
  output logic [7:0] temp_core1,
  output logic [7:0] temp_core2,
  output logic       byte_valid,
  output logic       frame_valid,
  output logic       framing_err,
  output logic       sync_lost
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);

  // Reject configurations the mid-bit sampling scheme cannot handle.
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || TIMEOUT_BITS < 1) begin : g_param_check
    $error("uart_temp_frame_rx: OVERSAMPLE must be even and >= 4, TIMEOUT_BITS >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       shift;
  logic             rx_meta;
  logic             rx_s;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  logic [TO_W-1:0] idle_cnt;
`else
  assign sync_lost = 1'b0;
`endif

  always_ff @(posedge tranclk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      shift       <= '0;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      temp_core0  <= '0;
      temp_core1  <= '0;
      temp_core2  <= '0;
      byte_valid  <= 1'b0;
      frame_valid <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      idle_cnt    <= '0;
      sync_lost   <= 1'b0;
`endif
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      byte_valid  <= 1'b0;
      frame_valid <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      sync_lost   <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
`ifdef UART_RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
`ifdef UART_RX_TIMEOUT_EN
          // A stalled partial frame is abandoned so the next byte lands in slot 0.
          else if (byte_idx != 2'd0) begin
            if (idle_cnt == TO_W'(TO_LIMIT - 1)) begin
              byte_idx  <= 2'd0;
              sync_lost <= 1'b1;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
`endif
        end

        START: begin
          // Re-check the line at mid start bit; a glitch returns quietly to IDLE.
          if (cnt == HALF_LAST) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            shift[bit_idx] <= rx_s;
            cnt            <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              state      <= IDLE;
              // Slot index 3 cannot occur; it is handled as slot 0.
              case (byte_idx)
                2'd1: begin
                  temp_core1 <= shift;
                  byte_idx   <= 2'd2;
                end
                2'd2: begin
                  temp_core2  <= shift;
                  byte_idx    <= 2'd0;
                  frame_valid <= 1'b1;
                end
                default: begin
                  temp_core0 <= shift;
                  byte_idx   <= 2'd1;
                end
              endcase
            end else begin
              framing_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A held-low line (break) must not be decoded as a stream of zero bytes.
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
